// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: pops one byte at a time, strobes Tx_WR and paces on Tx_BUSY,
// re-issuing the strobe when the transmitter never acknowledges. Optional overflow counter: UART_TX_FIFO_DROP_CNT_EN.
module uart_tx_fifo #(
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int BUSY_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [7:0]        i_wr_data,
    input  logic              i_wr_en,
    input  logic              i_flush,
    input  logic              i_enable,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_wr,
    input  logic              i_tx_busy
`ifdef UART_TX_FIFO_DROP_CNT_EN
    ,
    output logic [7:0]        o_drop_cnt
`endif
);

    localparam int TMR_W = $clog2(BUSY_WAIT) + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     w_count_nxt;
    logic                r_full;
    logic                r_empty;
    logic [7:0]          r_tx_data;
    logic [7:0]          w_tx_data_nxt;
    logic                r_tx_wr;
    logic                w_tx_wr_nxt;
    logic [TMR_W-1:0]    r_timer;
    logic [TMR_W-1:0]    w_timer_nxt;
    logic                w_push;
    logic                w_pop;

    // A full FIFO drops the byte even when a pop frees a slot on the same edge; flush masks pushes.
    assign w_push = i_wr_en && !r_full && !i_flush;

    // Next occupancy: flush wins, otherwise push and pop net out.
    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + (ADDR_W+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - (ADDR_W+1)'(1);
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (i_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (ADDR_W+1)'(DEPTH));
            r_empty <= (w_count_nxt == (ADDR_W+1)'(0));
        end
    end

    // Dispatcher next-state and strobe/data/timer next values.
    always_comb begin
        w_state_nxt   = r_state;
        w_tx_wr_nxt   = 1'b0;
        w_tx_data_nxt = r_tx_data;
        w_timer_nxt   = r_timer;
        w_pop         = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_enable && !r_empty) begin
                    w_pop         = 1'b1;
                    w_tx_data_nxt = r_mem[r_rd_ptr];
                    w_tx_wr_nxt   = 1'b1;
                    w_state_nxt   = LAUNCH;
                end else begin
                    w_state_nxt   = IDLE;
                end
            end
            LAUNCH: begin
                w_timer_nxt = '0;
                w_state_nxt = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_state_nxt = WAIT_DONE;
                end else if (r_timer == TMR_W'(BUSY_WAIT - 1)) begin
                    // Transmitter missed the strobe: re-issue the same byte.
                    w_tx_wr_nxt = 1'b1;
                    w_state_nxt = LAUNCH;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Dispatcher state and registered transmitter interface.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_tx_wr   <= 1'b0;
            r_tx_data <= 8'h00;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tx_wr   <= w_tx_wr_nxt;
            r_tx_data <= w_tx_data_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating count of pushes rejected because the FIFO was full.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_drop_cnt <= 8'h00;
        end else if (i_wr_en && r_full && !i_flush && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_count   = r_count;
    assign o_tx_data = r_tx_data;
    assign o_tx_wr   = r_tx_wr;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; a behavioural transmitter stub answers Tx_WR with a Tx_BUSY window
// and logs every strobed byte.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] wr_data = 8'h00;
    logic       wr_en = 1'b0;
    logic       flush = 1'b0;
    logic       enable = 1'b1;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       tx_busy = 1'b0;
`ifdef UART_TX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    logic       mock_en = 1'b1;
    int         busy_cnt = 0;
    int         pulses = 0;
    logic [7:0] rxq [$];

    int total = 0;
    int bad = 0;

    uart_tx_fifo dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_wr_data (wr_data),
        .i_wr_en   (wr_en),
        .i_flush   (flush),
        .i_enable  (enable),
        .o_full    (full),
        .o_empty   (empty),
        .o_count   (count),
        .o_tx_data (tx_data),
        .o_tx_wr   (tx_wr),
        .i_tx_busy (tx_busy)
`ifdef UART_TX_FIFO_DROP_CNT_EN
        ,
        .o_drop_cnt(drop_cnt)
`endif
    );

    always #10 clk = ~clk;

    // Transmitter stub: every strobe is logged; when enabled it answers with a 6-cycle busy window.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
            tx_busy  = 1'b0;
        end else begin
            if (tx_wr) begin
                pulses++;
                rxq.push_back(tx_data);
                if (mock_en) busy_cnt = 6;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_busy = (busy_cnt > 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int k;
        k = 0;
        while (rxq.size() < n && k < 400) begin
            step();
            k++;
        end
        chk("rx_wait", rxq.size(), n);
    endtask

    initial begin
        int base;
        int pbase;
        int k;
        logic [7:0] exp_b;

        // Reset state
        reset = 1'b1;
        step();
        step();
        chk("rst_count", count, 4'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_tx_wr", tx_wr, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        reset = 1'b0;
        step();

        // Single-byte latency
        base = rxq.size();
        push(8'hA5);
        chk("lat_count_k", count, 4'd1);
        chk("lat_wr_k", tx_wr, 1'b0);
        step();
        chk("lat_wr_k1", tx_wr, 1'b1);
        chk("lat_data_k1", tx_data, 8'hA5);
        chk("lat_count_k1", count, 4'd0);
        step();
        chk("lat_wr_k2", tx_wr, 1'b0);
        wait_rx(base + 1);
        chk("lat_byte", rxq[base], 8'hA5);
        repeat (12) step();

        // Burst of four queued while held, then released
        base = rxq.size();
        pbase = pulses;
        enable = 1'b0;
        push(8'hFA); push(8'h07); push(8'hC4); push(8'hFF);
        chk("burst_count", count, 4'd4);
        enable = 1'b1;
        wait_rx(base + 4);
        repeat (12) step();
        chk("burst_pulses", pulses - pbase, 4);
        chk("burst_b0", rxq[base], 8'hFA);
        chk("burst_b1", rxq[base + 1], 8'h07);
        chk("burst_b2", rxq[base + 2], 8'hC4);
        chk("burst_b3", rxq[base + 3], 8'hFF);
        chk("burst_empty", empty, 1'b1);

        // Overflow: ninth byte dropped
        base = rxq.size();
        enable = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        chk("ovf_full8", full, 1'b1);
        chk("ovf_count8", count, 4'd8);
        push(8'h09);
        chk("ovf_count9", count, 4'd8);
        chk("ovf_full9", full, 1'b1);
`ifdef UART_TX_FIFO_DROP_CNT_EN
        chk("ovf_drop", drop_cnt, 8'd1);
`endif
        enable = 1'b1;
        wait_rx(base + 8);
        repeat (16) step();
        chk("ovf_rx_n", rxq.size(), base + 8);
        for (int i = 0; i < 8; i++) begin
            exp_b = 8'(i + 1);
            chk("ovf_byte", rxq[base + i], exp_b);
        end

        // Push and pop on the same edge
        base = rxq.size();
        enable = 1'b0;
        push(8'hB1); push(8'hB2);
        chk("pp_count_pre", count, 4'd2);
        enable  = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hB3;
        step();
        wr_en   = 1'b0;
        chk("pp_count", count, 4'd2);
        chk("pp_tx_wr", tx_wr, 1'b1);
        chk("pp_tx_data", tx_data, 8'hB1);
        wait_rx(base + 3);
        repeat (12) step();
        chk("pp_b0", rxq[base], 8'hB1);
        chk("pp_b1", rxq[base + 1], 8'hB2);
        chk("pp_b2", rxq[base + 2], 8'hB3);

        // Pointer wrap: six queued, three sent, five more queued
        base = rxq.size();
        enable = 1'b0;
        for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
        enable = 1'b1;
        wait_rx(base + 3);
        enable = 1'b0;
        chk("wrap_count3", count, 4'd3);
        for (int i = 6; i < 11; i++) push(8'hC0 + 8'(i));
        chk("wrap_count8", count, 4'd8);
        chk("wrap_full", full, 1'b1);
        enable = 1'b1;
        wait_rx(base + 11);
        repeat (12) step();
        for (int i = 0; i < 11; i++) begin
            exp_b = 8'hC0 + 8'(i);
            chk("wrap_byte", rxq[base + i], exp_b);
        end
        chk("wrap_empty", empty, 1'b1);

        // Busy never rises: strobe repeats every 5 cycles; then reset mid-operation
        mock_en = 1'b0;
        push(8'h5A);
        k = 0;
        while (tx_wr !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        chk("to_first", tx_wr, 1'b1);
        repeat (4) step();
        chk("to_gap", tx_wr, 1'b0);
        step();
        chk("to_repulse", tx_wr, 1'b1);
        chk("to_data", tx_data, 8'h5A);
        chk("to_count", count, 4'd0);
        push(8'h11); push(8'h22); push(8'h33);
        chk("to_count3", count, 4'd3);
        reset = 1'b1;
        step();
        chk("mrst_tx_wr", tx_wr, 1'b0);
        chk("mrst_count", count, 4'd0);
        chk("mrst_empty", empty, 1'b1);
        chk("mrst_tx_data", tx_data, 8'h00);
        reset = 1'b0;
        mock_en = 1'b1;
        repeat (3) step();

        // Flush while the first byte is in flight; concurrent push ignored
        base = rxq.size();
        pbase = pulses;
        for (int i = 0; i < 5; i++) push(8'hD1 + 8'(i));
        wait_rx(base + 1);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hEE;
        step();
        flush   = 1'b0;
        wr_en   = 1'b0;
        chk("fl_count", count, 4'd0);
        chk("fl_empty", empty, 1'b1);
        repeat (40) step();
        chk("fl_rx_n", rxq.size(), base + 1);
        chk("fl_byte", rxq[base], 8'hD1);
        chk("fl_pulses", pulses - pbase, 1);
        chk("fl_empty_end", empty, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
